i2c_cmd_arb: RTL and testbench



---
 rtl/i2c_cmd_arb.sv | 162 ++++++++++++++++
 tb/tb_i2c_cmd_arb.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arb.sv
// Round-robin arbiter and sequencer sharing one I2C byte-write engine.
// Grants a requester, runs its transfer with NACK retry, then holds a bus-free gap.
module i2c_cmd_arb #(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT   = 1023,
    parameter int GAP_CYC   = 8,
    parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk2,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_ctrl,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 eng_start,
    output logic                 eng_abort,
    output logic [7:0]           eng_ctrl,
    output logic [7:0]           eng_data,
    input  logic                 eng_done,
    input  logic                 eng_nack
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CNT_W = $clog2(GAP_CYC + 1);

    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF,
        RESP,
        GAP
    } state_t;

    state_t state;

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  idx;
    logic             pick_ok;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic [RTY_W-1:0] retry;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] sel;

    // First requesting index after the last grant; lowest offset wins.
    always_comb begin
        pick_ok = 1'b0;
        pick_id = '0;
        idx     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last) + i) % N_REQ);
            if (req[idx]) begin
                pick_ok = 1'b1;
                pick_id = idx;
            end
        end
    end

    // Saturating WAIT timer so a stuck engine cannot wrap the count.
    always_comb begin
        timer_nxt = (timer == TMR_MAX) ? timer : timer + 1'b1;
    end

    assign sel = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

    // Main sequencer: grant, issue, wait/retry, respond, bus-free gap.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            eng_ctrl  <= '0;
            eng_data  <= '0;
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            done      <= '0;
            err       <= '0;
            busy      <= 1'b0;
            retry     <= '0;
            timer     <= '0;
            cnt       <= '0;
        end else begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            done      <= '0;
            err       <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant_id  <= pick_id;
                        last      <= pick_id;
                        eng_ctrl  <= req_ctrl[{pick_id, 3'b000} +: 8];
                        eng_data  <= req_data[{pick_id, 3'b000} +: 8];
                        retry     <= '0;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer_nxt;
                    if (eng_done) begin
                        if (!eng_nack) begin
                            done  <= sel;
                            state <= RESP;
                        end else if (retry < RTY_MAX) begin
                            retry <= retry + 1'b1;
                            cnt   <= '0;
                            state <= BACKOFF;
                        end else begin
                            done  <= sel;
                            err   <= sel;
                            state <= RESP;
                        end
                    end else if (timer_nxt == TMR_MAX) begin
                        eng_abort <= 1'b1;
                        done      <= sel;
                        err       <= sel;
                        state     <= RESP;
                    end
                end
                BACKOFF: begin
                    if (cnt == CNT_LAST) begin
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == CNT_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arb.sv
// Directed testbench for i2c_cmd_arb.
// Each task drives one scenario and checks outputs against hand-computed values.
module tb_i2c_cmd_arb;

    logic        clk2 = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_ctrl = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic [1:0]  grant_id;
    logic        eng_start;
    logic        eng_abort;
    logic [7:0]  eng_ctrl;
    logic [7:0]  eng_data;
    logic        eng_done = 1'b0;
    logic        eng_nack = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_done = 0;

    i2c_cmd_arb #(
        .N_REQ(4),
        .MAX_RETRY(2),
        .TIMEOUT(1023),
        .GAP_CYC(8)
    ) dut (
        .clk2(clk2),
        .reset(reset),
        .req(req),
        .req_ctrl(req_ctrl),
        .req_data(req_data),
        .done(done),
        .err(err),
        .busy(busy),
        .grant_id(grant_id),
        .eng_start(eng_start),
        .eng_abort(eng_abort),
        .eng_ctrl(eng_ctrl),
        .eng_data(eng_data),
        .eng_done(eng_done),
        .eng_nack(eng_nack)
    );

    always #5 clk2 = ~clk2;

    // Count start and done pulses seen by the engine side.
    always @(posedge clk2) begin
        if (eng_start === 1'b1) n_start++;
        if (|done) n_done++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic ack(input logic nack);
        eng_done = 1'b1;
        eng_nack = nack;
        tick(1);
        eng_done = 1'b0;
        eng_nack = 1'b0;
    endtask

    task automatic wait_start(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (eng_start === 1'b1) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s no eng_start within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s busy stuck high", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if ({done, err, busy, grant_id, eng_start, eng_abort, eng_ctrl, eng_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got done=%b err=%b busy=%b gid=%0d st=%b ab=%b c=%h d=%h exp all 0",
                     done, err, busy, grant_id, eng_start, eng_abort, eng_ctrl, eng_data);
        end
        reset = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b start=%b exp 0 0", busy, eng_start);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        req_ctrl = 32'h33_22_11_00;
        req_data = 32'hD3_C2_B1_A0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_start("rr_start", 30);
            checks++;
            if (grant_id !== 2'(k)) begin
                failures++;
                $display("FAIL rr_grant got=%0d exp=%0d", grant_id, k);
            end
            checks++;
            if (eng_data !== 8'(8'hA0 + 8'h11 * k)) begin
                failures++;
                $display("FAIL rr_data got=%h exp=%h", eng_data, 8'(8'hA0 + 8'h11 * k));
            end
            tick(3);
            ack(1'b0);
            exp = 4'(1 << k);
            checks++;
            if (done !== exp || err !== 4'b0000) begin
                failures++;
                $display("FAIL rr_done got=%b/%b exp=%b/0000", done, err, exp);
            end
            req[k] = 1'b0;
            wait_idle("rr_idle");
        end
        req = 4'b0011;
        wait_start("rr2_start0", 30);
        checks++;
        if (grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rr2_first got=%0d exp=0", grant_id);
        end
        tick(2);
        ack(1'b0);
        req[0] = 1'b0;
        tick(2);
        req[0] = 1'b1;
        wait_idle("rr2_idle0");
        wait_start("rr2_start1", 30);
        checks++;
        if (grant_id !== 2'd1) begin
            failures++;
            $display("FAIL rr2_second got=%0d exp=1", grant_id);
        end
        tick(2);
        ack(1'b0);
        req[1] = 1'b0;
        wait_idle("rr2_idle1");
        wait_start("rr2_start2", 30);
        checks++;
        if (grant_id !== 2'd0) begin
            failures++;
            $display("FAIL rr2_third got=%0d exp=0", grant_id);
        end
        tick(2);
        ack(1'b0);
        req = 4'b0000;
        wait_idle("rr2_idle2");
    endtask

    task automatic test_single();
        req_ctrl[23:16] = 8'h00;
        req_data[23:16] = 8'hAF;
        n_start = 0;
        req = 4'b0100;
        wait_start("single_start", 20);
        checks++;
        if (eng_ctrl !== 8'h00 || eng_data !== 8'hAF || grant_id !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_latch got c=%h d=%h gid=%0d busy=%b exp 00 af 2 1",
                     eng_ctrl, eng_data, grant_id, busy);
        end
        tick(19);
        ack(1'b0);
        checks++;
        if (done !== 4'b0100 || err !== 4'b0000) begin
            failures++;
            $display("FAIL single_done got=%b/%b exp=0100/0000", done, err);
        end
        req = 4'b0000;
        tick(1);
        checks++;
        if (done !== 4'b0000) begin
            failures++;
            $display("FAIL single_pulse got=%b exp=0000", done);
        end
        tick(7);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_gap_busy got=%b exp=1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_low got=%b exp=0", busy);
        end
        checks++;
        if (n_start !== 1) begin
            failures++;
            $display("FAIL single_nstart got=%0d exp=1", n_start);
        end
    endtask

    task automatic test_nack_retries();
        req_ctrl[15:8] = 8'h80;
        req_data[15:8] = 8'h3C;
        n_start = 0;
        req = 4'b0010;
        for (int a = 0; a < 3; a++) begin
            if (a == 0) begin
                wait_start("nack_start", 20);
            end else begin
                tick(7);
                checks++;
                if (eng_start !== 1'b0) begin
                    failures++;
                    $display("FAIL nack_early got=%b exp=0", eng_start);
                end
                tick(1);
                checks++;
                if (eng_start !== 1'b1) begin
                    failures++;
                    $display("FAIL nack_restart got=%b exp=1", eng_start);
                end
            end
            checks++;
            if (eng_ctrl !== 8'h80 || eng_data !== 8'h3C) begin
                failures++;
                $display("FAIL nack_bytes got=%h/%h exp=80/3c", eng_ctrl, eng_data);
            end
            tick(5);
            ack(1'b1);
            checks++;
            if (a < 2) begin
                if (done !== 4'b0000) begin
                    failures++;
                    $display("FAIL nack_nodone got=%b exp=0000", done);
                end
            end else begin
                if (done !== 4'b0010 || err !== 4'b0010) begin
                    failures++;
                    $display("FAIL nack_err got=%b/%b exp=0010/0010", done, err);
                end
            end
        end
        req = 4'b0000;
        wait_idle("nack_idle");
        checks++;
        if (n_start !== 3) begin
            failures++;
            $display("FAIL nack_nstart got=%0d exp=3", n_start);
        end
    endtask

    task automatic test_nack_then_ack();
        n_start = 0;
        req = 4'b0010;
        wait_start("na_start", 20);
        tick(4);
        ack(1'b1);
        tick(8);
        checks++;
        if (eng_start !== 1'b1) begin
            failures++;
            $display("FAIL na_restart got=%b exp=1", eng_start);
        end
        tick(4);
        ack(1'b0);
        checks++;
        if (done !== 4'b0010 || err !== 4'b0000) begin
            failures++;
            $display("FAIL na_done got=%b/%b exp=0010/0000", done, err);
        end
        req = 4'b0000;
        wait_idle("na_idle");
        checks++;
        if (n_start !== 2) begin
            failures++;
            $display("FAIL na_nstart got=%0d exp=2", n_start);
        end
    endtask

    task automatic test_timeout();
        req = 4'b0001;
        wait_start("to_start", 20);
        tick(1023);
        checks++;
        if (eng_abort !== 1'b0 || done !== 4'b0000) begin
            failures++;
            $display("FAIL to_early got ab=%b done=%b exp 0 0000", eng_abort, done);
        end
        tick(1);
        checks++;
        if (eng_abort !== 1'b1 || done !== 4'b0001 || err !== 4'b0001) begin
            failures++;
            $display("FAIL to_abort got ab=%b done=%b err=%b exp 1 0001 0001",
                     eng_abort, done, err);
        end
        req = 4'b0000;
        tick(1);
        checks++;
        if (eng_abort !== 1'b0) begin
            failures++;
            $display("FAIL to_abort_pulse got=%b exp=0", eng_abort);
        end
        wait_idle("to_idle");
        req = 4'b0100;
        wait_start("race_start", 20);
        tick(1023);
        eng_done = 1'b1;
        tick(1);
        eng_done = 1'b0;
        checks++;
        if (eng_abort !== 1'b0 || done !== 4'b0100 || err !== 4'b0000) begin
            failures++;
            $display("FAIL to_race got ab=%b done=%b err=%b exp 0 0100 0000",
                     eng_abort, done, err);
        end
        req = 4'b0000;
        wait_idle("race_idle");
    endtask

    task automatic test_reset_mid();
        req = 4'b0010;
        wait_start("rm_start", 20);
        tick(3);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || eng_ctrl !== 8'h00 ||
            eng_data !== 8'h00 || done !== 4'b0000) begin
            failures++;
            $display("FAIL rm_async got busy=%b gid=%0d c=%h d=%h done=%b exp all 0",
                     busy, grant_id, eng_ctrl, eng_data, done);
        end
        req = 4'b0000;
        n_done = 0;
        tick(2);
        reset = 1'b1;
        tick(20);
        checks++;
        if (n_done !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_nodone got ndone=%0d busy=%b exp 0 0", n_done, busy);
        end
        req_ctrl[31:24] = 8'h40;
        req = 4'b1000;
        wait_start("rm_start3", 20);
        checks++;
        if (grant_id !== 2'd3 || eng_ctrl !== 8'h40) begin
            failures++;
            $display("FAIL rm_grant got gid=%0d c=%h exp 3 40", grant_id, eng_ctrl);
        end
        tick(2);
        ack(1'b0);
        checks++;
        if (done !== 4'b1000 || err !== 4'b0000) begin
            failures++;
            $display("FAIL rm_done got=%b/%b exp=1000/0000", done, err);
        end
        req = 4'b0000;
        wait_idle("rm_idle");
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_nack_retries();
        test_nack_then_ack();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
